// File: rtl/palette_fader_if.sv
// Pixel-side bus of the palette fader: index/valid/frame timing in, blended RGB
// plus fade status out.
interface palette_fader_if #(
  parameter int INDEX_WIDTH = 3,
  parameter int COLOR_WIDTH = 8,
  parameter int RATE_WIDTH  = 8
);
  logic [INDEX_WIDTH-1:0] palette_index;
  logic                   pixel_valid;
  logic                   frame_start;
  logic                   night_req;
  logic [COLOR_WIDTH-1:0] red;
  logic [COLOR_WIDTH-1:0] green;
  logic [COLOR_WIDTH-1:0] blue;
  logic                   out_valid;
  logic [RATE_WIDTH-1:0]  night_rate;
  logic                   fading;

  modport master (
    output palette_index, pixel_valid, frame_start, night_req,
    input  red, green, blue, out_valid, night_rate, fading
  );

  modport slave (
    input  palette_index, pixel_valid, frame_start, night_req,
    output red, green, blue, out_valid, night_rate, fading
  );
endinterface

// File: rtl/palette_fader.sv
// Palette lookup with a frame-paced day/night fade toward the inverted palette.
// Two-stage pipeline: stage 1 looks up the entry, stage 2 blends each channel.
module palette_fader #(
  parameter int INDEX_WIDTH     = 3,
  parameter int COLOR_WIDTH     = 8,
  parameter int MAX_NIGHT_RATE  = 255,
  parameter int FADE_STEP       = 1,
  parameter int FRAMES_PER_STEP = 1,
  parameter int NIGHT_INIT      = 0,
  parameter logic [(2**INDEX_WIDTH)*3*COLOR_WIDTH-1:0] PALETTE = {
    24'hFFFFFF, 24'hF5F7F4, 24'hD8DBD7, 24'hB8BAB7,
    24'h747673, 24'h5E605D, 24'h525451, 24'h000000
  }
) (
  input logic              clk,
  input logic              rst_n,
  palette_fader_if.slave   bus
);
  localparam int CW     = COLOR_WIDTH;
  localparam int CW3    = 3 * CW;
  localparam int RW     = $clog2(MAX_NIGHT_RATE + 1);
  localparam int CNT_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int STAGES = 2;
  localparam int STEP_C = (FADE_STEP > MAX_NIGHT_RATE) ? MAX_NIGHT_RATE : FADE_STEP;
  // Signed blend width: |(MAX-2r)*orig| < 2^(RW+1+CW), plus sum and sign bits.
  localparam int W      = RW + CW + 3;

  localparam logic [RW-1:0]       RMAX     = RW'(MAX_NIGHT_RATE);
  localparam logic [RW-1:0]       STEP     = RW'(STEP_C);
  localparam logic [RW-1:0]       RINIT    = RW'(NIGHT_INIT);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic signed [W-1:0] CMAX_S   = W'((2**CW) - 1);
  localparam logic signed [W-1:0] MAX_S    = W'(MAX_NIGHT_RATE);

  logic [RW-1:0]       rate_q, rate_d, target, gap;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CW3-1:0]      entry, s1_rgb_q;
  logic [RW-1:0]       s1_rate_q;
  logic [STAGES:1]     vld_pipe_q;
  logic signed [W-1:0] r_s;
  logic [2:0][CW-1:0]  chan;

  assign target = bus.night_req ? RMAX : '0;
  assign gap    = (target > rate_q) ? (target - rate_q) : (rate_q - target);

  // Rate only moves on frame_start; the final step clamps onto the target.
  always_comb begin
    rate_d = rate_q;
    cnt_d  = cnt_q;
    if (bus.frame_start) begin
      if (rate_q == target) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (gap <= STEP)         rate_d = target;
        else if (target > rate_q) rate_d = rate_q + STEP;
        else                      rate_d = rate_q - STEP;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_q <= RINIT;
      cnt_q  <= '0;
    end else begin
      rate_q <= rate_d;
      cnt_q  <= cnt_d;
    end
  end

  assign entry = PALETTE[CW3*int'(bus.palette_index) +: CW3];

  // Stage 1 samples rate_q, so a pixel sharing a frame_start cycle sees the old rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rgb_q   <= '0;
      s1_rate_q  <= '0;
      vld_pipe_q <= '0;
    end else begin
      s1_rgb_q   <= entry;
      s1_rate_q  <= rate_q;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], bus.pixel_valid};
    end
  end

  assign r_s = signed'(W'(s1_rate_q));

  // Lane 0 = blue, 1 = green, 2 = red, matching the packed {R,G,B} entry layout.
  for (genvar ch = 0; ch < 3; ch++) begin : g_lane
    logic signed [W-1:0] o_s, num;
    logic [CW-1:0]       chan_q;

    assign o_s = signed'(W'(s1_rgb_q[ch*CW +: CW]));
    // num = r*(CMAX-orig) + orig*(MAX-r) >= 0, so the quotient is already the floor.
    assign num = r_s * CMAX_S + (MAX_S - (r_s <<< 1)) * o_s;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chan_q <= '0;
      else        chan_q <= CW'(num / MAX_S);
    end

    assign chan[ch] = chan_q;
  end

  assign bus.red        = chan[2];
  assign bus.green      = chan[1];
  assign bus.blue       = chan[0];
  assign bus.out_valid  = vld_pipe_q[STAGES];
  assign bus.night_rate = rate_q;
  assign bus.fading     = (rate_q != target);
endmodule

// File: tb/tb_palette_fader.sv
// Directed bench for palette_fader: one day-start and one night-start instance,
// RGB checked through per-instance expected-value queues.
module tb_palette_fader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [23:0] qd[$];
  logic [23:0] qn[$];
  logic [1:0]  evd, evn;

  int pal [8][3] = '{'{0,0,0}, '{82,84,81}, '{94,96,93}, '{116,118,115},
                     '{184,186,183}, '{216,219,215}, '{245,247,244}, '{255,255,255}};

  always #5 clk = ~clk;

  palette_fader_if #(.INDEX_WIDTH(3), .COLOR_WIDTH(8), .RATE_WIDTH(8)) ifd ();
  palette_fader_if #(.INDEX_WIDTH(3), .COLOR_WIDTH(8), .RATE_WIDTH(8)) ifn ();

  palette_fader #(.FADE_STEP(16), .FRAMES_PER_STEP(2), .NIGHT_INIT(0)) u_day (
    .clk(clk), .rst_n(rst_n), .bus(ifd));
  palette_fader #(.FADE_STEP(64), .FRAMES_PER_STEP(1), .NIGHT_INIT(255)) u_night (
    .clk(clk), .rst_n(rst_n), .bus(ifn));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input int r, input int idx);
    logic [23:0] res;
    int c;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      c = (r * 255 + (255 - 2 * r) * pal[idx][ch]) / 255;
      res[(2-ch)*8 +: 8] = 8'(c);
    end
    return res;
  endfunction

  // Expected out_valid: the driven pixel_valid delayed by two clocks.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evd <= '0;
      evn <= '0;
    end else begin
      evd <= {evd[0], ifd.pixel_valid};
      evn <= {evn[0], ifn.pixel_valid};
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("day_out_valid", 32'(ifd.out_valid), 32'(evd[1]));
      if (ifd.out_valid === 1'b1) begin
        if (qd.size() == 0) begin
          n_vec++; n_err++;
          $error("FAIL day_sb: observed unexpected pixel expected none");
        end else chk("day_rgb", {8'h0, ifd.red, ifd.green, ifd.blue}, {8'h0, qd.pop_front()});
      end
      chk("night_out_valid", 32'(ifn.out_valid), 32'(evn[1]));
      if (ifn.out_valid === 1'b1) begin
        if (qn.size() == 0) begin
          n_vec++; n_err++;
          $error("FAIL night_sb: observed unexpected pixel expected none");
        end else chk("night_rgb", {8'h0, ifn.red, ifn.green, ifn.blue}, {8'h0, qn.pop_front()});
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    ifd.pixel_valid = 1'b0; ifd.frame_start = 1'b0;
    ifn.pixel_valid = 1'b0; ifn.frame_start = 1'b0;
  endtask

  task automatic pix(input bit night, input int idx, input logic [23:0] expv, input bit fs);
    logic [31:0] iv;
    iv = 32'(idx);
    @(posedge clk); #1;
    if (night) begin
      ifn.palette_index = iv[2:0]; ifn.pixel_valid = 1'b1; ifn.frame_start = fs;
      qn.push_back(expv);
    end else begin
      ifd.palette_index = iv[2:0]; ifd.pixel_valid = 1'b1; ifd.frame_start = fs;
      qd.push_back(expv);
    end
  endtask

  task automatic pulse(input bit night);
    @(posedge clk); #1;
    if (night) ifn.frame_start = 1'b1; else ifd.frame_start = 1'b1;
    @(posedge clk); #1;
    ifn.frame_start = 1'b0; ifd.frame_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int er;
    ifd.palette_index = '0; ifd.pixel_valid = 1'b0; ifd.frame_start = 1'b0; ifd.night_req = 1'b0;
    ifn.palette_index = '0; ifn.pixel_valid = 1'b0; ifn.frame_start = 1'b0; ifn.night_req = 1'b1;

    // Reset state
    #22;
    chk("rst_day_valid", 32'(ifd.out_valid), 0);
    chk("rst_day_rgb",   {8'h0, ifd.red, ifd.green, ifd.blue}, 0);
    chk("rst_day_rate",  32'(ifd.night_rate), 0);
    chk("rst_day_fading", 32'(ifd.fading), 0);
    chk("rst_night_valid", 32'(ifn.out_valid), 0);
    chk("rst_night_rgb",  {8'h0, ifn.red, ifn.green, ifn.blue}, 0);
    chk("rst_night_rate", 32'(ifn.night_rate), 255);
    chk("rst_night_fading", 32'(ifn.fading), 0);
    @(negedge clk); rst_n = 1'b1;

    // Endpoints: rate 0 is the original colour, rate MAX its inverse
    pix(0, 3, 24'h747673, 0);
    pix(0, 0, 24'h000000, 0);
    idle();
    pix(1, 3, 24'h8B898C, 0);
    pix(1, 0, 24'hFFFFFF, 0);
    pix(1, 7, 24'h000000, 0);
    idle();
    wait_cyc(3);

    // Day instance ramps to 96, every second frame_start
    ifd.night_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      pulse(0);
      chk("ramp96_rate", 32'(ifd.night_rate), 32'(16 * (k / 2)));
      chk("ramp96_fading", 32'(ifd.fading), 1);
    end

    // Reverse at 96: ramps back down and holds at 0
    ifd.night_req = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      pulse(0);
      er = 96 - 16 * (k / 2);
      if (er < 0) er = 0;
      chk("down_rate", 32'(ifd.night_rate), 32'(er));
      chk("down_fading", 32'(ifd.fading), 32'(er != 0));
    end

    // Full ramp to 255 with a pixel sampled at rate 128, then hold
    ifd.night_req = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      pulse(0);
      er = 16 * (k / 2);
      if (er > 255) er = 255;
      chk("up_rate", 32'(ifd.night_rate), 32'(er));
      chk("up_fading", 32'(ifd.fading), 32'(k < 32));
      if (k == 16) begin
        pix(0, 1, 24'h7F7F7F, 0);
        idle();
      end
    end

    // Back-to-back stream; frame_start on the 4th pixel steps 255 -> 191
    ifn.night_req = 1'b0;
    @(negedge clk);
    chk("stream_pre_fading", 32'(ifn.fading), 1);
    chk("stream_pre_rate", 32'(ifn.night_rate), 255);
    for (int i = 0; i < 8; i++)
      pix(1, i, exp_rgb((i < 4) ? 255 : 191, i), (i == 3));
    idle();
    wait_cyc(3);
    chk("stream_post_rate", 32'(ifn.night_rate), 191);
    for (int k = 1; k <= 4; k++) begin
      pulse(1);
      er = 191 - 64 * k;
      if (er < 0) er = 0;
      chk("night_down_rate", 32'(ifn.night_rate), 32'(er));
      chk("night_down_fading", 32'(ifn.fading), 32'(er != 0));
    end

    // Reset in the middle of a stream
    pix(1, 5, exp_rgb(0, 5), 0);
    pix(1, 6, exp_rgb(0, 6), 0);
    pix(1, 7, exp_rgb(0, 7), 0);
    chk("midrst_pre_valid", 32'(ifn.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_night_valid", 32'(ifn.out_valid), 0);
    chk("midrst_night_rgb", {8'h0, ifn.red, ifn.green, ifn.blue}, 0);
    chk("midrst_night_rate", 32'(ifn.night_rate), 255);
    chk("midrst_day_valid", 32'(ifd.out_valid), 0);
    chk("midrst_day_rgb", {8'h0, ifd.red, ifd.green, ifd.blue}, 0);
    chk("midrst_day_rate", 32'(ifd.night_rate), 0);
    qd.delete(); qn.delete();
    ifn.pixel_valid = 1'b0; ifd.pixel_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    pix(0, 6, 24'hF5F7F4, 0);
    idle();
    wait_cyc(4);
    chk("sb_drain", 32'(qd.size() + qn.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
